int_to_flopoco: RTL and testbench

- Iterative converter from a signed two's-complement integer to the FloPoCo floating-point word that our FP subtract/compare datapath consumes.
- Word layout, MSB first:
  - exception field, 2 bits;
  - sign, 1 bit;
  - exponent, WE bits, biased;
  - mantissa, WF bits, implicit leading 1.
- Sits upstream of the comparators. Produces FP operands (box bounds, ray origins) from integer scene coordinates.
- valid/ready handshake on both sides; multi-cycle normalisation by a one-bit-per-cycle left shifter.

---
 rtl/flopoco_fmt_pkg.sv | 33 +++
 rtl/int_to_flopoco_if.sv | 23 ++
 rtl/fp_round_pack.sv | 49 ++++
 rtl/int_to_flopoco.sv | 110 +++++++++++
 tb/tb_int_to_flopoco.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/flopoco_fmt_pkg.sv
// FloPoCo word format constants, field offsets and converter states.
// Shared by the integer-to-FloPoCo converter and its packer.
package flopoco_fmt_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    function automatic int exc_lsb(input int we, input int wf);
        return we + wf + 1;
    endfunction

    function automatic int sign_pos(input int we, input int wf);
        return we + wf;
    endfunction

    function automatic int exp_lsb(input int wf);
        return wf;
    endfunction

    function automatic int bias(input int we);
        return (1 << (we - 1)) - 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ABS,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/int_to_flopoco_if.sv
// valid/ready bundle between integer source, converter and FP consumer.
// master drives integers in and takes results out; slave is the converter.
interface int_to_flopoco_if #(
    parameter int IW = 16,
    parameter int OW = 15
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_round_pack.sv
// Packs a normalised magnitude into a FloPoCo word.
// Define INT_TO_FLOPOCO_ROUND_NEAREST_EN for round-to-nearest-even.
module fp_round_pack
    import flopoco_fmt_pkg::*;
#(
    parameter int IW  = 16,
    parameter int WE  = 11,
    parameter int WF  = 1,
    parameter int LZW = $clog2(IW)
) (
    input  logic [IW-1:0]     mag,
    input  logic [LZW-1:0]    lz,
    input  logic              sign,
    output logic [WE+WF+2:0]  word
);
    localparam logic [WE-1:0] EXP_TOP = WE'(bias(WE) + IW - 1);

    logic [WE-1:0] exp_t;
    logic [WF-1:0] mant_t;

    assign exp_t  = EXP_TOP - WE'(lz);
    assign mant_t = mag[IW-2 -: WF];

`ifdef INT_TO_FLOPOCO_ROUND_NEAREST_EN
    // Mask of the bits below the guard position; empty when WF = IW-2.
    localparam logic [IW-1:0] SMASK =
        (IW'(1) << (IW - 2 - WF)) - IW'(1);

    logic          guard;
    logic          sticky;
    logic          inc;
    logic          carry;
    logic [WF-1:0] mant_r;
    logic [WE-1:0] exp_r;

    assign guard  = mag[IW-2-WF];
    assign sticky = |(mag & SMASK);
    assign inc    = guard & (sticky | mant_t[0]);
    assign {carry, mant_r} = {1'b0, mant_t} + {{WF{1'b0}}, inc};
    assign exp_r  = exp_t + WE'(carry);
    assign word   = {EXC_NORMAL, sign, exp_r, mant_r};
`else
    logic unused_bits;

    assign unused_bits = ^{mag[IW-1], mag[IW-2-WF:0]};
    assign word        = {EXC_NORMAL, sign, exp_t, mant_t};
`endif

endmodule

// File: rtl/int_to_flopoco.sv
// Iterative signed-integer to FloPoCo converter, one shift per cycle.
// Rounding mode selected by INT_TO_FLOPOCO_ROUND_NEAREST_EN.
module int_to_flopoco
    import flopoco_fmt_pkg::*;
#(
    parameter int IW = 16,
    parameter int WE = 11,
    parameter int WF = 1
) (
    input  logic clk,
    input  logic rst,
    int_to_flopoco_if.slave bus
);
    localparam int OW  = WE + WF + 3;
    localparam int LZW = $clog2(IW);

    state_t          state, state_n;
    logic [IW-1:0]   din, din_n;
    logic [IW-1:0]   mag, mag_n;
    logic [LZW-1:0]  lz, lz_n;
    logic            sign, sign_n;
    logic            ov, ov_n;
    logic [OW-1:0]   od, od_n;
    logic [OW-1:0]   packed_w;

    fp_round_pack #(
        .IW  (IW),
        .WE  (WE),
        .WF  (WF),
        .LZW (LZW)
    ) u_pack (
        .mag  (mag),
        .lz   (lz),
        .sign (sign),
        .word (packed_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            din   <= '0;
            mag   <= '0;
            lz    <= '0;
            sign  <= 1'b0;
            ov    <= 1'b0;
            od    <= '0;
        end else begin
            state <= state_n;
            din   <= din_n;
            mag   <= mag_n;
            lz    <= lz_n;
            sign  <= sign_n;
            ov    <= ov_n;
            od    <= od_n;
        end
    end

    always_comb begin
        state_n = state;
        din_n   = din;
        mag_n   = mag;
        lz_n    = lz;
        sign_n  = sign;
        ov_n    = ov;
        od_n    = od;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    din_n   = bus.in_data;
                    state_n = ABS;
                end
            end
            ABS: begin
                // Negating -2^(IW-1) wraps to 2^(IW-1): exact unsigned.
                sign_n = din[IW-1];
                mag_n  = din[IW-1] ? (IW'(0) - din) : din;
                lz_n   = '0;
                if (din == '0) begin
                    od_n    = '0;
                    ov_n    = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = NORM;
                end
            end
            NORM: begin
                if (!mag[IW-1]) begin
                    mag_n = mag << 1;
                    lz_n  = lz + LZW'(1);
                end else begin
                    od_n    = packed_w;
                    ov_n    = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    ov_n    = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov;
    assign bus.out_data  = od;

endmodule

// File: tb/tb_int_to_flopoco.sv
// Directed scoreboard bench for int_to_flopoco (IW=16, WE=11, WF=1).
// Expected words follow INT_TO_FLOPOCO_ROUND_NEAREST_EN.
module tb_int_to_flopoco;

    localparam int IW = 16;
    localparam int WE = 11;
    localparam int WF = 1;
    localparam int OW = WE + WF + 3;

`ifdef INT_TO_FLOPOCO_ROUND_NEAREST_EN
    localparam logic [OW-1:0] EXP_7     = 15'h2804;
    localparam logic [OW-1:0] EXP_32767 = 15'h281C;
`else
    localparam logic [OW-1:0] EXP_7     = 15'h2803;
    localparam logic [OW-1:0] EXP_32767 = 15'h281B;
`endif

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [OW-1:0] sbq[$];

    int_to_flopoco_if #(.IW(IW), .OW(OW)) bus ();

    int_to_flopoco #(.IW(IW), .WE(WE), .WF(WF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [IW-1:0] v, input logic [OW-1:0] w,
                          input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_idle"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(posedge clk);
        sbq.push_back(w);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = IW'($urandom);
        check({tag, "_busy"}, 32'(bus.in_ready), 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic compare_out(input string tag);
        logic [OW-1:0] e;
        e = (sbq.size() > 0) ? sbq.pop_front() : '1;
        check({tag, "_data"}, 32'(bus.out_data), 32'(e));
    endtask

    task automatic convert(input logic [IW-1:0] v, input logic [OW-1:0] w,
                           input int lat, input string tag);
        int n;
        accept(v, w, tag);
        wait_valid(n);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        compare_out(tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_drop"}, 32'(bus.out_valid), 0);
        check({tag, "_back"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [OW-1:0] held;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_ready", 32'(bus.in_ready), 1);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_data", 32'(bus.out_data), 0);
        @(negedge clk);
        rst = 1'b0;

        convert(16'h0000, 15'h0000, 1, "zero");
        convert(16'h0001, 15'h27FE, 17, "one");
        convert(16'hFFFF, 15'h37FE, 17, "mone");
        convert(16'h0003, 15'h2801, 16, "three");
        convert(16'hFFFB, 15'h3802, 15, "m5");
        convert(16'h0007, EXP_7, 15, "seven");
        convert(16'h8000, 15'h381C, 2, "mmin");
        convert(16'h7FFF, EXP_32767, 3, "max");

        // Backpressure with noise on the input side.
        accept(16'h0003, 15'h2801, "bp");
        wait_valid(n);
        check("bp_lat", 32'(n), 16);
        held = bus.out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = IW'($urandom);
            @(posedge clk); #1;
            check("bp_hold", 32'(bus.out_data), 32'(held));
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_ready", 32'(bus.in_ready), 0);
        end
        compare_out("bp");
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drop", 32'(bus.out_valid), 0);
        check("bp_back", 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_nocap", 32'(bus.out_valid), 0);
        check("bp_idle", 32'(bus.in_ready), 1);

        // Asynchronous reset in the middle of normalisation.
        accept(16'h0001, 15'h27FE, "rmid");
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rmid_valid", 32'(bus.out_valid), 0);
        check("rmid_ready", 32'(bus.in_ready), 1);
        check("rmid_data", 32'(bus.out_data), 0);
        if (sbq.size() > 0) void'(sbq.pop_front());
        @(negedge clk);
        rst = 1'b0;
        convert(16'h0003, 15'h2801, 16, "after");

        check("sb_empty", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
